// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED (16,11) decoder: FSM state codes,
// status codes and the position of each message bit inside an encoded word.
`timescale 1ns/1ps
package hamming_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD_LO  = 3'd1;
  localparam state_t ST_RD_HI  = 3'd2;
  localparam state_t ST_CAP_HI = 3'd3;
  localparam state_t ST_DECODE = 3'd4;
  localparam state_t ST_WR_LO  = 3'd5;
  localparam state_t ST_WR_HI  = 3'd6;
  localparam state_t ST_FINISH = 3'd7;

  localparam logic [1:0] STAT_CLEAN = 2'b00;
  localparam logic [1:0] STAT_CORR  = 2'b01;
  localparam logic [1:0] STAT_DBL   = 2'b10;

  localparam int DATA_BITS = 11;

  // Hamming position of message bit j (d1 is index 0); parity bits use 0,1,2,4,8
  localparam logic [3:0] DATA_POS [DATA_BITS] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  function automatic logic [DATA_BITS-1:0] extract_data(input logic [15:0] w);
    logic [DATA_BITS-1:0] d;
    d = '0;
    for (int j = 0; j < DATA_BITS; j++) begin
      d[j] = w[DATA_POS[j]];
    end
    return d;
  endfunction

endpackage

// File: rtl/secded_16_11_dec.sv
// Combinational SECDED (16,11) decode: syndrome, overall parity, single-bit
// correction and message extraction with a 2-bit status.
`timescale 1ns/1ps
module secded_16_11_dec
  import hamming_pkg::*;
(
  input  logic [15:0] w,
  output logic [10:0] data,
  output logic [1:0]  status
);

  logic [3:0]  syndrome;
  logic        parity;
  logic [15:0] fixed;

  always_comb begin
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) begin
        syndrome = syndrome ^ 4'(k);
      end
    end
    parity = ^w;

    fixed  = w;
    status = STAT_CLEAN;
    // Odd parity means one flipped bit; syndrome 0 points at p0 itself
    if (parity) begin
      fixed[syndrome] = ~w[syndrome];
      status          = STAT_CORR;
    end else if (syndrome != 4'd0) begin
      status = STAT_DBL;
    end

    data = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_decoder.sv
// SECDED (16,11) decoder engine: reads encoded words from the shared byte
// memory, decodes them and writes message plus status back, 6 cycles per word.
`timescale 1ns/1ps
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int         NUM_WORDS = 15,
  parameter logic [7:0] SRC_BASE  = 8'd30,
  parameter logic [7:0] DST_BASE  = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [7:0] corr_cnt,
  output logic [7:0] dbl_cnt
);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] res_lo_q, res_lo_d;
  logic [7:0] res_hi_q, res_hi_d;
  logic [7:0] corr_cnt_q, corr_cnt_d;
  logic [7:0] dbl_cnt_q, dbl_cnt_d;

  logic [10:0] dec_data;
  logic [1:0]  dec_status;
  logic [7:0]  word_off;
  logic [7:0]  src_lo, src_hi, dst_lo, dst_hi;
  logic        last_word;

  secded_16_11_dec u_dec (
    .w      ({hi_q, lo_q}),
    .data   (dec_data),
    .status (dec_status)
  );

  // Byte offsets wrap modulo 256 by construction of the 8-bit sums
  always_comb begin
    word_off  = {1'b0, idx_q, 1'b0};
    src_lo    = SRC_BASE + word_off;
    src_hi    = src_lo + 8'd1;
    dst_lo    = DST_BASE + word_off;
    dst_hi    = dst_lo + 8'd1;
    last_word = (idx_q == 6'(NUM_WORDS - 1));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    corr_cnt_d = corr_cnt_q;
    dbl_cnt_d  = dbl_cnt_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d    = ST_RD_LO;
          idx_d      = 6'd0;
          corr_cnt_d = 8'd0;
          dbl_cnt_d  = 8'd0;
        end
      end
      ST_RD_LO:  state_d = ST_RD_HI;
      ST_RD_HI: begin
        lo_d    = mem_rdata;
        state_d = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        hi_d    = mem_rdata;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        res_lo_d = dec_data[7:0];
        res_hi_d = {dec_status, 3'b000, dec_data[10:8]};
        if (dec_status == STAT_CORR) begin
          corr_cnt_d = corr_cnt_q + 8'd1;
        end else if (dec_status == STAT_DBL) begin
          dbl_cnt_d = dbl_cnt_q + 8'd1;
        end
        state_d = ST_WR_LO;
      end
      ST_WR_LO:  state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (last_word) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = ST_RD_LO;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 6'd0;
      lo_q       <= 8'd0;
      hi_q       <= 8'd0;
      res_lo_q   <= 8'd0;
      res_hi_q   <= 8'd0;
      corr_cnt_q <= 8'd0;
      dbl_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      corr_cnt_q <= corr_cnt_d;
      dbl_cnt_q  <= dbl_cnt_d;
    end
  end

  // Memory strobes are decoded from registered state only
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    case (state_q)
      ST_RD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = src_lo;
      end
      ST_RD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = src_hi;
      end
      ST_WR_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_lo;
        mem_wdata = res_lo_q;
      end
      ST_WR_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_hi;
        mem_wdata = res_hi_q;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  always_comb begin
    done     = (state_q == ST_FINISH);
    busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    corr_cnt = corr_cnt_q;
    dbl_cnt  = dbl_cnt_q;
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder with a byte-wide memory
// model and an independent encoder/flip-injection reference.
`timescale 1ns/1ps
module tb_hamming_decoder;

  localparam int NUM_WORDS = 15;
  localparam int SRC       = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] corr_cnt;
  logic [7:0] dbl_cnt;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  logic [7:0] tb_data = 8'd0;
  int         wr_count = 0;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_lo [NUM_WORDS];
  logic [7:0] exp_hi [NUM_WORDS];
  logic [7:0] prev_res [30];
  int         exp_corr;
  int         exp_dbl;
  int         wc_snap;

  always #5 clk = ~clk;

  hamming_decoder #(
    .NUM_WORDS (NUM_WORDS),
    .SRC_BASE  (8'd30),
    .DST_BASE  (8'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .corr_cnt  (corr_cnt),
    .dbl_cnt   (dbl_cnt)
  );

  // Synchronous single-port memory; the bench preload port shares the array
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_output("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] addr, input logic [7:0] data);
    tb_addr = addr;
    tb_data = data;
    tb_we   = 1'b1;
    tick();
    tb_we   = 1'b0;
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] w;
    w = 16'd0;
    {w[15], w[14], w[13], w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]} = m;
    w[1] = w[3] ^ w[5] ^ w[7] ^ w[9] ^ w[11] ^ w[13] ^ w[15];
    w[2] = w[3] ^ w[6] ^ w[7] ^ w[10] ^ w[11] ^ w[14] ^ w[15];
    w[4] = w[5] ^ w[6] ^ w[7] ^ w[12] ^ w[13] ^ w[14] ^ w[15];
    w[8] = ^w[15:9];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    return {w[15], w[14], w[13], w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]};
  endfunction

  // Expected results follow from the injected flips, not from a syndrome
  task automatic apply_stimulus(input bit directed);
    logic [15:0] w;
    logic [10:0] m;
    logic [10:0] raw;
    int          nflip;
    int          a;
    int          b;
    logic [15:0] dir_w  [4];
    logic [7:0]  dir_lo [4];
    logic [7:0]  dir_hi [4];
    dir_w  = '{16'hFFFF, 16'h0008, 16'h0001, 16'h0006};
    dir_lo = '{8'hFF, 8'h00, 8'h00, 8'h00};
    dir_hi = '{8'h07, 8'h40, 8'h40, 8'h80};
    exp_corr = 0;
    exp_dbl  = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (directed && i < 4) begin
        w         = dir_w[i];
        exp_lo[i] = dir_lo[i];
        exp_hi[i] = dir_hi[i];
        if (i == 1 || i == 2) exp_corr++;
        if (i == 3) exp_dbl++;
      end else begin
        m     = 11'($urandom_range(0, 2047));
        w     = encode(m);
        nflip = int'($urandom_range(0, 2));
        a     = int'($urandom_range(0, 15));
        b     = (a + int'($urandom_range(1, 15))) % 16;
        if (nflip >= 1) w[a] = ~w[a];
        if (nflip == 2) w[b] = ~w[b];
        case (nflip)
          0: begin
            exp_lo[i] = m[7:0];
            exp_hi[i] = {5'b00000, m[10:8]};
          end
          1: begin
            exp_lo[i] = m[7:0];
            exp_hi[i] = {5'b01000, m[10:8]};
            exp_corr++;
          end
          default: begin
            raw       = extract(w);
            exp_lo[i] = raw[7:0];
            exp_hi[i] = {5'b10000, raw[10:8]};
            exp_dbl++;
          end
        endcase
      end
      load_byte(8'(SRC + 2 * i), w[7:0]);
      load_byte(8'(SRC + 2 * i + 1), w[15:8]);
    end
  endtask

  task automatic run_full(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    check_output({tag, "_done_after_start"}, {31'd0, done}, 32'd0);
    for (int e = 2; e <= 91; e++) begin
      tick();
      if (e == 90) check_output({tag, "_done_edge90"}, {31'd0, done}, 32'd0);
    end
    check_output({tag, "_done_edge91"}, {31'd0, done}, 32'd1);
    check_output({tag, "_busy_edge91"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < NUM_WORDS; i++) begin
      check_output($sformatf("%s_res%0d_lo", tag, i), {24'd0, mem[2 * i]}, {24'd0, exp_lo[i]});
      check_output($sformatf("%s_res%0d_hi", tag, i), {24'd0, mem[2 * i + 1]}, {24'd0, exp_hi[i]});
    end
    check_output({tag, "_corr_cnt"}, {24'd0, corr_cnt}, 32'(exp_corr));
    check_output({tag, "_dbl_cnt"}, {24'd0, dbl_cnt}, 32'(exp_dbl));
    tick();
    check_output({tag, "_done_held"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_output("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_output("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check_output("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check_output("rst_corr_cnt", {24'd0, corr_cnt}, 32'd0);
    check_output("rst_dbl_cnt", {24'd0, dbl_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    check_output("idle_no_start", {31'd0, busy}, 32'd0);

    // Run 1: directed corner words followed by random ones, from IDLE
    apply_stimulus(1'b1);
    run_full("run1");

    // Run 2: started from FINISH, reset hits during word 5 with START high
    for (int i = 0; i < 30; i++) prev_res[i] = mem[i];
    apply_stimulus(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (33) tick();
    check_output("run2_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check_output("rst_mid_done", {31'd0, done}, 32'd0);
    check_output("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_output("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_output("rst_mid_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_output("rst_mid_corr_cnt", {24'd0, corr_cnt}, 32'd0);
    check_output("rst_mid_dbl_cnt", {24'd0, dbl_cnt}, 32'd0);
    wc_snap = wr_count;
    reset = 1'b0;
    start = 1'b0;
    repeat (10) tick();
    check_output("rst_mid_no_writes", 32'(wr_count), 32'(wc_snap));
    check_output("rst_mid_stays_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("run2_res%0d_lo", i), {24'd0, mem[2 * i]}, {24'd0, exp_lo[i]});
      check_output($sformatf("run2_res%0d_hi", i), {24'd0, mem[2 * i + 1]}, {24'd0, exp_hi[i]});
    end
    for (int i = 10; i < 30; i++) begin
      check_output($sformatf("rst_mid_keep%0d", i), {24'd0, mem[i]}, {24'd0, prev_res[i]});
    end

    // Run 3: full run from IDLE after the aborted one
    apply_stimulus(1'b0);
    run_full("run3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Hardware SECDED (16,11) decoder engine: the receive side of the Hamming encode program. On START it walks NUM_WORDS encoded 16-bit words in byte-wide data memory and computes each word's syndrome and overall parity. It writes the corrected 11-bit message plus a 2-bit error status back to memory, then raises DONE. It shares the single-port data memory with the datapath; the top level grants the memory port to this block while it is busy.

## Interface
- NUM_WORDS, 15: encoded words processed per run (1..64)
- SRC_BASE, 30: byte address of word 0 low byte; word i at SRC_BASE+2i (low), SRC_BASE+2i+1 (high)
- DST_BASE, 0: byte address of result 0 low byte; same 2-byte stride
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  run request, sampled only in IDLE or FINISH
- DONE  out  1  high while in FINISH
- BUSY  out  1  high in any state other than IDLE/FINISH
- MEM_ADDR  out  8  data-memory byte address
- MEM_RD  out  1  read strobe; MEM_RDATA valid the following cycle
- MEM_RDATA  in  8  read data
- MEM_WR  out  1  write strobe, written at this edge
- MEM_WDATA  out  8  write data
- CORR_CNT  out  8  words with a single corrected error this run
- DBL_CNT  out  8  words with a detected double error this run

## Operation
- Encoded word w[15:0] = {high byte, low byte}. Bit k (1..15) is Hamming position k; bit 0 is overall parity p0. Parity bits sit at positions 1, 2, 4, 8. Data bits are d1=w3, d2=w5, d3=w6, d4=w7, d5..d11=w9..w15.
- Syndrome s[3:0] = XOR of indices k (1..15) where w[k]=1. Overall parity P = ^w[15:0].
- s=0, P=0: clean, status 2'b00.
- P=1: single error at bit s (s=0 means p0). Flip w[s], status 2'b01, CORR_CNT+1.
- s≠0, P=0: double error. Data is not modified, status 2'b10, DBL_CNT+1.
- Status 2'b11 is never produced.
- Result low byte = {w12,w11,w10,w9,w7,w6,w5,w3} taken after correction.
- Result high byte = {status[1:0],3'b000,w15,w14,w13}.
- FSM states: IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, FINISH.
- IDLE→RD_LO on START. The same transition clears the word index, CORR_CNT and DBL_CNT.
- RD_LO: MEM_RD=1, MEM_ADDR=SRC_BASE+2i.
- RD_HI: MEM_RD=1, MEM_ADDR=SRC_BASE+2i+1; capture low byte.
- CAP_HI: capture high byte.
- DECODE: register the result bytes, and update the counters once.
- WR_LO: MEM_WR=1, MEM_ADDR=DST_BASE+2i.
- WR_HI: MEM_WR=1, MEM_ADDR=DST_BASE+2i+1. Then go to RD_LO with i+1 if i<NUM_WORDS-1, else to FINISH.
- FINISH: DONE=1 and is held. START returns to RD_LO and starts a new run. Without START the block stays in FINISH.
- Address arithmetic is 8-bit and wraps modulo 256. No error is raised on wrap.
- Source and destination regions may overlap. Each word is read completely before its result is written.

## Timing
- Reset values: state IDLE; DONE, BUSY, MEM_RD, MEM_WR = 0; MEM_ADDR, MEM_WDATA = 0; CORR_CNT, DBL_CNT = 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from input to output.
- Throughput is 6 cycles per word. With the START-sampling edge counted as edge 1, DONE is first high after edge 6·NUM_WORDS+1. That is 91 for the default.
- RESET has priority over everything, including mid-run. It returns the block to IDLE within one edge, drops all strobes and clears the counters. Memory bytes already written are left as they are.
- START is ignored while BUSY. START and RESET high together resolves to RESET.
- MEM_RD and MEM_WR are never high in the same cycle.

## Structure
- Shared package hamming_pkg holds:
  - the state enum
  - the status codes (STAT_CLEAN, STAT_CORR, STAT_DBL)
  - the data-bit position constants, so they can be reused by the encoder-side bench model
- Sub-module secded_16_11_dec is purely combinational. Input w[15:0]. Outputs data[10:0] and status[1:0].
- The FSM, counters and memory sequencing live in hamming_decoder.

## Test plan
- Word 0xFFFF (message 0x7FF) → result bytes 0xFF, 0x07; counters unchanged.
- Word 0x0008 (single error at position 3) → result bytes 0x00, 0x40; CORR_CNT=1.
- Word 0x0001 (p0 flipped) → result bytes 0x00, 0x40; CORR_CNT=1; data bits untouched.
- Word 0x0006 (double error) → result bytes 0x00, 0x80; DBL_CNT=1.
- 15 random encoded messages, each with 0, 1 or 2 random bit flips, at bytes 30..59 → bytes 0..29 match the reference model. DONE first high at edge 91. Counters match the injected flips.
- RESET asserted during word 5 → DONE=0, BUSY=0 next cycle; no MEM_WR afterward; bytes 10..29 unchanged. A following START completes a full run normally.
